// File: rtl/drp_lb_pkg.sv
// Shared types and constants for the DRP local-bus master.
// Optional WAIT timeout is enabled by defining DRP_LB_MASTER_TIMEOUT_EN.
package drp_lb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } drp_state_e;

   localparam int DRP_ADDR_W_DEF = 12;
   localparam int DRP_DATA_W_DEF = 16;
   localparam int DRP_DATA_W_MAX = 64;

   // Read data returned when a DRP access times out: 'width' low bits set.
   function automatic logic [DRP_DATA_W_MAX-1:0] tmo_rdata(input int width);
      logic [DRP_DATA_W_MAX-1:0] v;
      v = '0;
      for (int i = 0; i < DRP_DATA_W_MAX; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/drp_req_slot.sv
// Single-entry holding slot for a request that arrives while the master is busy.
// A simultaneous load and pop leaves the slot full with the newly loaded request.
module drp_req_slot
   import drp_lb_pkg::*;
#(
   parameter int C_ADDR_WIDTH = DRP_ADDR_W_DEF,
   parameter int C_DATA_WIDTH = DRP_DATA_W_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic                    pop_i,
   input  logic                    we_i,
   input  logic [C_ADDR_WIDTH-1:0] addr_i,
   input  logic [C_DATA_WIDTH-1:0] data_i,
   output logic                    full_o,
   output logic                    we_o,
   output logic [C_ADDR_WIDTH-1:0] addr_o,
   output logic [C_DATA_WIDTH-1:0] data_o
);

   logic                    valid_q;
   logic                    we_q;
   logic [C_ADDR_WIDTH-1:0] addr_q;
   logic [C_DATA_WIDTH-1:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         we_q    <= we_i;
         addr_q  <= addr_i;
         data_q  <= data_i;
      end else if (pop_i) begin
         valid_q <= 1'b0;
      end
   end

   assign full_o = valid_q;
   assign we_o   = we_q;
   assign addr_o = addr_q;
   assign data_o = data_q;

endmodule

// File: rtl/drp_lb_master.sv
// Local-bus to DRP bridge: one DRP access at a time plus one pending request.
// Define DRP_LB_MASTER_TIMEOUT_EN to bound the wait for DRPRDY.
module drp_lb_master
   import drp_lb_pkg::*;
#(
   parameter int C_ADDR_WIDTH     = DRP_ADDR_W_DEF,
   parameter int C_DATA_WIDTH     = DRP_DATA_W_DEF,
   parameter int C_TIMEOUT_CYCLES = 1023
) (
   input  logic                    CLK_I,
   input  logic                    RST_I,
   input  logic [C_ADDR_WIDTH-1:0] S_LB_WADDR,
   input  logic [C_DATA_WIDTH-1:0] S_LB_WDATA,
   input  logic                    S_LB_WREQ,
   input  logic [C_ADDR_WIDTH-1:0] S_LB_RADDR,
   input  logic                    S_LB_RREQ,
   output logic [C_DATA_WIDTH-1:0] S_LB_RDATA,
   output logic                    S_LB_RFINISH,
   output logic                    S_LB_WFINISH,
   output logic                    S_LB_BUSY,
   output logic                    S_LB_ERR,
   output logic                    M_DRPEN,
   output logic                    M_DRPWE,
   output logic [C_ADDR_WIDTH-1:0] M_DRPADDR,
   output logic [C_DATA_WIDTH-1:0] M_DRPDI,
   input  logic                    M_DRPRDY,
   input  logic [C_DATA_WIDTH-1:0] M_DRPDO
);

   drp_state_e              state_q;
   logic                    drpen_q, drpwe_q, cur_we_q;
   logic                    rfin_q, wfin_q, err_q;
   logic [C_ADDR_WIDTH-1:0] addr_q;
   logic [C_DATA_WIDTH-1:0] di_q, rdata_q;

   logic                    slot_full, slot_we, slot_pop, slot_load;
   logic [C_ADDR_WIDTH-1:0] slot_addr;
   logic [C_DATA_WIDTH-1:0] slot_data;

   logic                    issue_go, issue_we, direct_w, direct_r, drop, space;
   logic [C_ADDR_WIDTH-1:0] issue_addr, store_addr;
   logic [C_DATA_WIDTH-1:0] issue_data, store_data;
   logic                    store_we;
   logic                    xfer_done, tmo_done;
   logic [C_DATA_WIDTH-1:0] done_rdata;

   // Pending slot has priority; a fresh request only issues directly from IDLE.
   always_comb begin
      slot_pop   = 1'b0;
      issue_go   = 1'b0;
      issue_we   = 1'b0;
      issue_addr = '0;
      issue_data = '0;
      direct_w   = 1'b0;
      direct_r   = 1'b0;
      slot_load  = 1'b0;
      store_we   = 1'b0;
      store_addr = '0;
      store_data = '0;
      drop       = 1'b0;
      if (state_q == ST_IDLE || state_q == ST_DONE) begin
         if (slot_full) begin
            slot_pop   = 1'b1;
            issue_go   = 1'b1;
            issue_we   = slot_we;
            issue_addr = slot_addr;
            issue_data = slot_data;
         end else if (state_q == ST_IDLE && S_LB_WREQ) begin
            issue_go   = 1'b1;
            issue_we   = 1'b1;
            issue_addr = S_LB_WADDR;
            issue_data = S_LB_WDATA;
            direct_w   = 1'b1;
         end else if (state_q == ST_IDLE && S_LB_RREQ) begin
            issue_go   = 1'b1;
            issue_addr = S_LB_RADDR;
            direct_r   = 1'b1;
         end
      end
      space = !slot_full || slot_pop;
      if (S_LB_WREQ && !direct_w) begin
         if (space) begin
            slot_load  = 1'b1;
            store_we   = 1'b1;
            store_addr = S_LB_WADDR;
            store_data = S_LB_WDATA;
         end else begin
            drop = 1'b1;
         end
      end
      if (S_LB_RREQ && !direct_r) begin
         if (space && !slot_load) begin
            slot_load  = 1'b1;
            store_addr = S_LB_RADDR;
         end else begin
            drop = 1'b1;
         end
      end
   end

   drp_req_slot #(
      .C_ADDR_WIDTH(C_ADDR_WIDTH),
      .C_DATA_WIDTH(C_DATA_WIDTH)
   ) u_slot (
      .clk_i (CLK_I),
      .rst_i (RST_I),
      .load_i(slot_load),
      .pop_i (slot_pop),
      .we_i  (store_we),
      .addr_i(store_addr),
      .data_i(store_data),
      .full_o(slot_full),
      .we_o  (slot_we),
      .addr_o(slot_addr),
      .data_o(slot_data)
   );

   assign xfer_done = (state_q == ST_ISSUE || state_q == ST_WAIT) && M_DRPRDY;

`ifdef DRP_LB_MASTER_TIMEOUT_EN
   localparam int                    CNT_W     = $clog2(C_TIMEOUT_CYCLES + 1);
   localparam logic [C_DATA_WIDTH-1:0] TMO_RDATA = C_DATA_WIDTH'(tmo_rdata(C_DATA_WIDTH));
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I)                    cnt_q <= '0;
      else if (state_q == ST_ISSUE) cnt_q <= '0;
      else if (state_q == ST_WAIT)  cnt_q <= cnt_q + 1'b1;
   end

   assign tmo_done   = (state_q == ST_WAIT) && !M_DRPRDY &&
                       (cnt_q == CNT_W'(C_TIMEOUT_CYCLES - 1));
   assign done_rdata = tmo_done ? TMO_RDATA : M_DRPDO;
`else
   assign tmo_done   = 1'b0;
   assign done_rdata = M_DRPDO;
`endif

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q  <= ST_IDLE;
         drpen_q  <= 1'b0;
         drpwe_q  <= 1'b0;
         cur_we_q <= 1'b0;
         rfin_q   <= 1'b0;
         wfin_q   <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         di_q     <= '0;
         rdata_q  <= '0;
      end else begin
         drpen_q <= 1'b0;
         drpwe_q <= 1'b0;
         rfin_q  <= 1'b0;
         wfin_q  <= 1'b0;
         err_q   <= drop | tmo_done;
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (issue_go) begin
                  state_q  <= ST_ISSUE;
                  drpen_q  <= 1'b1;
                  drpwe_q  <= issue_we;
                  cur_we_q <= issue_we;
                  addr_q   <= issue_addr;
                  di_q     <= issue_data;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (xfer_done || tmo_done) begin
                  state_q <= ST_DONE;
                  if (cur_we_q) begin
                     wfin_q <= 1'b1;
                  end else begin
                     rfin_q  <= 1'b1;
                     rdata_q <= done_rdata;
                  end
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign M_DRPEN      = drpen_q;
   assign M_DRPWE      = drpwe_q;
   assign M_DRPADDR    = addr_q;
   assign M_DRPDI      = di_q;
   assign S_LB_RDATA   = rdata_q;
   assign S_LB_RFINISH = rfin_q;
   assign S_LB_WFINISH = wfin_q;
   assign S_LB_ERR     = err_q;
   assign S_LB_BUSY    = (state_q != ST_IDLE) | slot_full;

endmodule

// File: tb/tb_drp_lb_master.sv
// Directed bench for drp_lb_master; the timeout scenario runs only when
// DRP_LB_MASTER_TIMEOUT_EN is defined.
module tb_drp_lb_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] waddr = '0, raddr = '0;
   logic [15:0] wdata = '0, drpdo = '0;
   logic        wreq = 1'b0, rreq = 1'b0, drprdy = 1'b0;
   logic [15:0] rdata, drpdi;
   logic [11:0] drpaddr;
   logic        rfin, wfin, busy, err, drpen, drpwe;

   int total = 0;
   int bad   = 0;
   int en_cnt = 0, err_cnt = 0, fin_cnt = 0, en_consec = 0, we_viol = 0;
   logic en_prev = 1'b0;
   int en0, err0, fin0;

   drp_lb_master #(
      .C_ADDR_WIDTH(12),
      .C_DATA_WIDTH(16),
      .C_TIMEOUT_CYCLES(8)
   ) dut (
      .CLK_I(clk), .RST_I(rst),
      .S_LB_WADDR(waddr), .S_LB_WDATA(wdata), .S_LB_WREQ(wreq),
      .S_LB_RADDR(raddr), .S_LB_RREQ(rreq),
      .S_LB_RDATA(rdata), .S_LB_RFINISH(rfin), .S_LB_WFINISH(wfin),
      .S_LB_BUSY(busy), .S_LB_ERR(err),
      .M_DRPEN(drpen), .M_DRPWE(drpwe), .M_DRPADDR(drpaddr), .M_DRPDI(drpdi),
      .M_DRPRDY(drprdy), .M_DRPDO(drpdo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (drpen && en_prev) en_consec++;
      en_prev = drpen;
      if (drpen) en_cnt++;
      if (drpwe && !drpen) we_viol++;
      if (err) err_cnt++;
      if (rfin || wfin) fin_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(); tick();
      total++;
      if ({drpen, drpwe, drpaddr, drpdi, rdata, rfin, wfin, busy, err} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0",
                         {drpen, drpwe, drpaddr, drpdi, rdata, rfin, wfin, busy, err});
      end
      rst = 1'b0;
      raddr = 12'h001; rreq = 1'b1;
      tick();
      rreq = 1'b0;
      total++;
      if ({drpen, drpwe, drpaddr} !== {1'b1, 1'b0, 12'h001}) begin
         bad++; $display("FAIL reset_first_edge got=%h exp=%h", {drpen, drpwe, drpaddr}, {1'b1, 1'b0, 12'h001});
      end
      drprdy = 1'b1; drpdo = 16'h0001;
      tick();
      drprdy = 1'b0; drpdo = '0;
      total++;
      if ({rfin, rdata} !== {1'b1, 16'h0001}) begin
         bad++; $display("FAIL reset_first_read got=%h exp=%h", {rfin, rdata}, {1'b1, 16'h0001});
      end
      tick();
   endtask

   task automatic test_write();
      waddr = 12'h012; wdata = 16'hBEEF; wreq = 1'b1;
      tick();
      wreq = 1'b0;
      total++;
      if ({drpen, drpwe, drpaddr, drpdi, busy} !== {1'b1, 1'b1, 12'h012, 16'hBEEF, 1'b1}) begin
         bad++; $display("FAIL wr_issue got=%h exp=%h", {drpen, drpwe, drpaddr, drpdi, busy},
                         {1'b1, 1'b1, 12'h012, 16'hBEEF, 1'b1});
      end
      tick();
      total++;
      if ({drpen, drpwe, busy, wfin} !== 4'b0010) begin
         bad++; $display("FAIL wr_wait got=%b exp=0010", {drpen, drpwe, busy, wfin});
      end
      tick(); tick();
      drprdy = 1'b1;
      tick();
      drprdy = 1'b0;
      total++;
      if ({wfin, rfin, drpaddr, drpdi} !== {1'b1, 1'b0, 12'h012, 16'hBEEF}) begin
         bad++; $display("FAIL wr_done got=%h exp=%h", {wfin, rfin, drpaddr, drpdi},
                         {1'b1, 1'b0, 12'h012, 16'hBEEF});
      end
      tick();
      total++;
      if ({wfin, busy, drpen} !== 3'b000) begin
         bad++; $display("FAIL wr_after got=%b exp=000", {wfin, busy, drpen});
      end
   endtask

   task automatic test_read();
      raddr = 12'h7FF; rreq = 1'b1;
      tick();
      rreq = 1'b0;
      total++;
      if ({drpen, drpwe, drpaddr} !== {1'b1, 1'b0, 12'h7FF}) begin
         bad++; $display("FAIL rd_issue got=%h exp=%h", {drpen, drpwe, drpaddr}, {1'b1, 1'b0, 12'h7FF});
      end
      tick();
      drprdy = 1'b1; drpdo = 16'h1234;
      tick();
      drprdy = 1'b0; drpdo = 16'h0000;
      total++;
      if ({rfin, wfin, rdata, busy} !== {1'b1, 1'b0, 16'h1234, 1'b1}) begin
         bad++; $display("FAIL rd_done got=%h exp=%h", {rfin, wfin, rdata, busy}, {1'b1, 1'b0, 16'h1234, 1'b1});
      end
      tick();
      total++;
      if ({busy, rfin, rdata} !== {1'b0, 1'b0, 16'h1234}) begin
         bad++; $display("FAIL rd_after got=%h exp=%h", {busy, rfin, rdata}, {1'b0, 1'b0, 16'h1234});
      end
      // Ready already present in the issue cycle skips WAIT.
      raddr = 12'h055; rreq = 1'b1;
      tick();
      rreq = 1'b0;
      drprdy = 1'b1; drpdo = 16'hA5A5;
      tick();
      drprdy = 1'b0; drpdo = 16'h0000;
      total++;
      if ({rfin, rdata} !== {1'b1, 16'hA5A5}) begin
         bad++; $display("FAIL rd_fast got=%h exp=%h", {rfin, rdata}, {1'b1, 16'hA5A5});
      end
      tick();
   endtask

   task automatic test_both();
      err0 = err_cnt;
      waddr = 12'h100; wdata = 16'h1111; raddr = 12'h200; wreq = 1'b1; rreq = 1'b1;
      tick();
      wreq = 1'b0; rreq = 1'b0;
      total++;
      if ({drpen, drpwe, drpaddr, drpdi} !== {1'b1, 1'b1, 12'h100, 16'h1111}) begin
         bad++; $display("FAIL both_wr_first got=%h exp=%h", {drpen, drpwe, drpaddr, drpdi},
                         {1'b1, 1'b1, 12'h100, 16'h1111});
      end
      drprdy = 1'b1;
      tick();
      drprdy = 1'b0;
      total++;
      if ({wfin, busy, drpen} !== 3'b110) begin
         bad++; $display("FAIL both_wfin got=%b exp=110", {wfin, busy, drpen});
      end
      tick();
      total++;
      if ({drpen, drpwe, drpaddr} !== {1'b1, 1'b0, 12'h200}) begin
         bad++; $display("FAIL both_rd_issue got=%h exp=%h", {drpen, drpwe, drpaddr}, {1'b1, 1'b0, 12'h200});
      end
      drprdy = 1'b1; drpdo = 16'h2222;
      tick();
      drprdy = 1'b0; drpdo = '0;
      total++;
      if ({rfin, rdata} !== {1'b1, 16'h2222}) begin
         bad++; $display("FAIL both_rd_done got=%h exp=%h", {rfin, rdata}, {1'b1, 16'h2222});
      end
      tick();
      total++;
      if ((err_cnt - err0) !== 0 || busy !== 1'b0) begin
         bad++; $display("FAIL both_err_busy got_err=%0d got_busy=%b exp_err=0 exp_busy=0", err_cnt - err0, busy);
      end
   endtask

   task automatic test_overflow();
      en0 = en_cnt; err0 = err_cnt;
      waddr = 12'h010; wdata = 16'hAAAA; wreq = 1'b1;
      tick();
      wreq = 1'b0;
      tick();
      raddr = 12'h020; rreq = 1'b1;
      tick();
      rreq = 1'b0;
      total++;
      if ({err, busy} !== 2'b01) begin
         bad++; $display("FAIL ovf_store got=%b exp=01", {err, busy});
      end
      waddr = 12'h030; wdata = 16'hCCCC; wreq = 1'b1;
      tick();
      wreq = 1'b0;
      total++;
      if ({err, drpaddr, drpdi} !== {1'b1, 12'h010, 16'hAAAA}) begin
         bad++; $display("FAIL ovf_drop got=%h exp=%h", {err, drpaddr, drpdi}, {1'b1, 12'h010, 16'hAAAA});
      end
      tick();
      total++;
      if (err !== 1'b0) begin
         bad++; $display("FAIL ovf_err_pulse got=%b exp=0", err);
      end
      drprdy = 1'b1;
      tick();
      drprdy = 1'b0;
      total++;
      if ({wfin, drpaddr} !== {1'b1, 12'h010}) begin
         bad++; $display("FAIL ovf_wfin got=%h exp=%h", {wfin, drpaddr}, {1'b1, 12'h010});
      end
      tick();
      total++;
      if ({drpen, drpwe, drpaddr} !== {1'b1, 1'b0, 12'h020}) begin
         bad++; $display("FAIL ovf_rd_issue got=%h exp=%h", {drpen, drpwe, drpaddr}, {1'b1, 1'b0, 12'h020});
      end
      drprdy = 1'b1; drpdo = 16'h0BAD;
      tick();
      drprdy = 1'b0; drpdo = '0;
      total++;
      if ({rfin, rdata} !== {1'b1, 16'h0BAD}) begin
         bad++; $display("FAIL ovf_rd_done got=%h exp=%h", {rfin, rdata}, {1'b1, 16'h0BAD});
      end
      tick(); tick();
      total++;
      if ((en_cnt - en0) !== 2 || (err_cnt - err0) !== 1 || busy !== 1'b0) begin
         bad++; $display("FAIL ovf_counts got_en=%0d got_err=%0d got_busy=%b exp_en=2 exp_err=1 exp_busy=0",
                         en_cnt - en0, err_cnt - err0, busy);
      end
   endtask

   task automatic test_reset_mid();
      fin0 = fin_cnt; err0 = err_cnt;
      waddr = 12'h040; wdata = 16'h5555; wreq = 1'b1;
      tick();
      wreq = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      total++;
      if ({drpen, drpwe, drpaddr, drpdi, rdata, rfin, wfin, busy, err} !== '0) begin
         bad++; $display("FAIL rstmid_outputs got=%h exp=0",
                         {drpen, drpwe, drpaddr, drpdi, rdata, rfin, wfin, busy, err});
      end
      tick();
      rst = 1'b0;
      tick();
      drprdy = 1'b1; drpdo = 16'h7777;
      tick();
      drprdy = 1'b0; drpdo = '0;
      tick();
      total++;
      if ({drpen, rfin, wfin, busy, rdata} !== '0 || fin_cnt !== fin0 || err_cnt !== err0) begin
         bad++; $display("FAIL rstmid_late_rdy got=%h fin=%0d err=%0d exp=0 fin=%0d err=%0d",
                         {drpen, rfin, wfin, busy, rdata}, fin_cnt, err_cnt, fin0, err0);
      end
      raddr = 12'h033; rreq = 1'b1;
      tick();
      rreq = 1'b0;
      total++;
      if ({drpen, drpwe, drpaddr} !== {1'b1, 1'b0, 12'h033}) begin
         bad++; $display("FAIL rstmid_next_issue got=%h exp=%h", {drpen, drpwe, drpaddr}, {1'b1, 1'b0, 12'h033});
      end
      drprdy = 1'b1; drpdo = 16'h4321;
      tick();
      drprdy = 1'b0; drpdo = '0;
      total++;
      if ({rfin, rdata} !== {1'b1, 16'h4321}) begin
         bad++; $display("FAIL rstmid_next_done got=%h exp=%h", {rfin, rdata}, {1'b1, 16'h4321});
      end
      tick();
   endtask

`ifdef DRP_LB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      raddr = 12'h0AA; rreq = 1'b1;
      tick();
      rreq = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         total++;
         if ({rfin, err} !== 2'b00) begin
            bad++; $display("FAIL tmo_wait_%0d got=%b exp=00", i, {rfin, err});
         end
      end
      tick();
      total++;
      if ({rfin, wfin, err, rdata} !== {1'b1, 1'b0, 1'b1, 16'hFFFF}) begin
         bad++; $display("FAIL tmo_done got=%h exp=%h", {rfin, wfin, err, rdata}, {1'b1, 1'b0, 1'b1, 16'hFFFF});
      end
      tick();
      total++;
      if ({busy, err, rfin} !== 3'b000) begin
         bad++; $display("FAIL tmo_after got=%b exp=000", {busy, err, rfin});
      end
   endtask
`endif

   task automatic test_invariants();
      total++;
      if (en_consec !== 0 || we_viol !== 0) begin
         bad++; $display("FAIL invariants en_consec=%0d we_without_en=%0d exp=0,0", en_consec, we_viol);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_both();
      test_overflow();
      test_reset_mid();
`ifdef DRP_LB_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
